// File: rtl/pipe_stream_accumulator_pkg.sv
// Shared types and constants for the pipeline stream accumulator.
// Package nnpu_pipe_pkg: FSM state type and saturation bounds for a given
// accumulator width (bounds are returned in 64 bits; callers keep the low ACC_W bits).
package nnpu_pipe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } psa_state_t;

    // Largest positive value representable in acc_w signed bits.
    function automatic logic [63:0] sat_max(input int acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    // Most negative value representable in acc_w signed bits (low acc_w bits: 100..0).
    function automatic logic [63:0] sat_min(input int acc_w);
        return {64{1'b1}} << (acc_w - 1);
    endfunction

endpackage

// File: rtl/pipe_stream_accumulator_if.sv
// Inter-stage link between the upstream pipeline register (master) and the
// accumulator (slave): term stream in, completed vector sums and status out.
interface pipe_stream_accumulator_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic                     enable_in;
    logic                     restart_in;
    logic signed [DATA_W-1:0] data_in;
    logic signed [ACC_W-1:0]  result_out;
    logic                     result_valid;
    logic                     overflow;
    logic                     dropped;
    logic                     busy;

    modport master (
        output enable_in, restart_in, data_in,
        input  result_out, result_valid, overflow, dropped, busy
    );

    modport slave (
        input  enable_in, restart_in, data_in,
        output result_out, result_valid, overflow, dropped, busy
    );
endinterface

// File: rtl/pipe_stream_accumulator_sat_add.sv
// psa_sat_add: combinational signed saturating adder. Adds two ACC_W-bit
// signed values and clamps to the representable range, flagging any clamp.
module psa_sat_add
    import nnpu_pipe_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sat
);
    localparam logic [63:0]      MAX64   = sat_max(ACC_W);
    localparam logic [63:0]      MIN64   = sat_min(ACC_W);
    localparam logic [ACC_W-1:0] SAT_MAX = MAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SAT_MIN = MIN64[ACC_W-1:0];

    logic [ACC_W:0] wide;

    // One guard bit: overflow shows up as disagreement between the two top bits,
    // and the guard bit tells the true sign of the unclamped sum.
    always_comb begin
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        sat  = wide[ACC_W] ^ wide[ACC_W-1];
        if (sat) begin
            sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = wide[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/pipe_stream_accumulator.sv
// pipe_stream_accumulator: receiving end of the NPU inter-stage link. Sums
// VEC_LEN signed terms per vector with saturation and emits one result per
// vector with a single-cycle valid pulse.
// Optional build macro PSA_RELU_EN: when defined, negative final sums are
// reported as 0 (overflow still reflects saturation).
module pipe_stream_accumulator
    import nnpu_pipe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int VEC_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_stream_accumulator_if.slave link
);
    localparam int              CNT_W    = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    psa_state_t              state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic                    sat_reg;
    logic signed [ACC_W-1:0] result_reg;
    logic                    valid_reg;
    logic                    ovf_reg;
    logic                    dropped_reg;

    logic signed [ACC_W-1:0] term_ext;
    logic signed [ACC_W-1:0] add_sum;
    logic                    add_sat;

    // Sign-extend the incoming term to accumulator width.
    assign term_ext = {{(ACC_W - DATA_W){link.data_in[DATA_W-1]}}, link.data_in};

    psa_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (acc_reg),
        .b   (term_ext),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Value presented on result_out for a completed vector sum.
    function automatic logic signed [ACC_W-1:0] out_val(input logic signed [ACC_W-1:0] v);
`ifdef PSA_RELU_EN
        return v[ACC_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Vector FSM, term counter, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            acc_reg     <= '0;
            sat_reg     <= 1'b0;
            result_reg  <= '0;
            valid_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            valid_reg   <= 1'b0;
            dropped_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // restart_in alone is meaningless here: nothing to discard.
                    if (link.enable_in) begin
                        if (VEC_LEN == 1) begin
                            result_reg <= out_val(term_ext);
                            ovf_reg    <= 1'b0;
                            valid_reg  <= 1'b1;
                        end else begin
                            acc_reg   <= term_ext;
                            count_reg <= CNT_W'(1);
                            sat_reg   <= 1'b0;
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (link.restart_in) begin
                        dropped_reg <= 1'b1;
                        if (link.enable_in && VEC_LEN != 1) begin
                            // Current term opens the replacement vector.
                            acc_reg   <= term_ext;
                            count_reg <= CNT_W'(1);
                            sat_reg   <= 1'b0;
                        end else if (link.enable_in) begin
                            result_reg <= out_val(term_ext);
                            ovf_reg    <= 1'b0;
                            valid_reg  <= 1'b1;
                            acc_reg    <= '0;
                            count_reg  <= '0;
                            sat_reg    <= 1'b0;
                            state_reg  <= IDLE;
                        end else begin
                            acc_reg   <= '0;
                            count_reg <= '0;
                            sat_reg   <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (link.enable_in) begin
                        if (count_reg == LAST_CNT) begin
                            result_reg <= out_val(add_sum);
                            ovf_reg    <= sat_reg | add_sat;
                            valid_reg  <= 1'b1;
                            acc_reg    <= '0;
                            count_reg  <= '0;
                            sat_reg    <= 1'b0;
                            state_reg  <= IDLE;
                        end else begin
                            acc_reg   <= add_sum;
                            count_reg <= count_reg + CNT_W'(1);
                            sat_reg   <= sat_reg | add_sat;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign link.result_out   = result_reg;
    assign link.result_valid = valid_reg;
    assign link.overflow     = ovf_reg;
    assign link.dropped      = dropped_reg;
    assign link.busy         = (state_reg == ACCUM);
endmodule

// File: tb/tb_pipe_stream_accumulator.sv
// Testbench for pipe_stream_accumulator. Two instances share one stimulus
// stream: dut_a at ACC_W=32 and dut_b at ACC_W=18, narrow enough that eight
// full-scale 16-bit terms clamp. Expected sums are pushed per vector; a
// monitor pops and compares on every result_valid pulse.
module tb_pipe_stream_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic rs  = 1'b0;
    logic signed [15:0] din = '0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int drops_a      = 0;
    int drops_b      = 0;

    typedef struct {
        longint val;
        bit     ovf;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   pulses_a[$];
    int   pulses_b[$];

    pipe_stream_accumulator_if #(.DATA_W(16), .ACC_W(32)) if_a ();
    pipe_stream_accumulator_if #(.DATA_W(16), .ACC_W(18)) if_b ();

    assign if_a.enable_in  = en;
    assign if_a.restart_in = rs;
    assign if_a.data_in    = din;
    assign if_b.enable_in  = en;
    assign if_b.restart_in = rs;
    assign if_b.data_in    = din;

    pipe_stream_accumulator #(.DATA_W(16), .ACC_W(32), .VEC_LEN(8)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .link (if_a)
    );

    pipe_stream_accumulator #(.DATA_W(16), .ACC_W(18), .VEC_LEN(8)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .link (if_b)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic longint relu(input longint v);
`ifdef PSA_RELU_EN
        return (v < 0) ? 64'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input longint va, input bit oa, input longint vb, input bit ob);
        exp_t e;
        e.val = va; e.ovf = oa; exp_a.push_back(e);
        e.val = vb; e.ovf = ob; exp_b.push_back(e);
    endtask

    // Inputs change on the falling edge and are held for one full cycle.
    task automatic drive(input bit e, input bit r, input int d);
        en  = e;
        rs  = r;
        din = 16'(d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    // Monitor: pops one expectation per result pulse, counts dropped pulses.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (if_a.result_valid) begin
                pulses_a.push_back(cyc);
                if (exp_a.size() == 0) begin
                    check("a_unexpected_valid", 1, 0);
                end else begin
                    e = exp_a.pop_front();
                    check("a_result", longint'($signed(if_a.result_out)), e.val);
                    check("a_overflow", longint'(if_a.overflow), longint'(e.ovf));
                end
            end
            if (if_b.result_valid) begin
                pulses_b.push_back(cyc);
                if (exp_b.size() == 0) begin
                    check("b_unexpected_valid", 1, 0);
                end else begin
                    e = exp_b.pop_front();
                    check("b_result", longint'($signed(if_b.result_out)), e.val);
                    check("b_overflow", longint'(if_b.overflow), longint'(e.ovf));
                end
            end
            if (if_a.dropped) drops_a++;
            if (if_b.dropped) drops_b++;
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int d0;
        // Reset state
        @(negedge clk);
        check("rst_result_a", longint'(if_a.result_out), 0);
        check("rst_valid_a", longint'(if_a.result_valid), 0);
        check("rst_busy_a", longint'(if_a.busy), 0);
        check("rst_ovf_b", longint'(if_b.overflow), 0);
        check("rst_dropped_b", longint'(if_b.dropped), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Vector 1..8 contiguous: 36, valid right after the eighth term
        push_exp(36, 0, 36, 0);
        drive(1, 0, 1);
        check("busy_after_first", longint'(if_a.busy), 1);
        for (int i = 2; i <= 8; i++) drive(1, 0, i);
        check("latency_valid_a", longint'(if_a.result_valid), 1);
        check("latency_valid_b", longint'(if_b.result_valid), 1);
        idle(1);
        check("busy_after_done", longint'(if_a.busy), 0);
        check("valid_one_cycle", longint'(if_a.result_valid), 0);
        check("result_held", longint'($signed(if_a.result_out)), 36);

        // -5 x8 with a bubble after each term
        push_exp(relu(-40), 0, relu(-40), 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, -5);
            idle(1);
        end
        idle(1);

        // 32767 x8: 262136 fits 32 bits; clamps to 2^17-1 at 18 bits
        push_exp(262136, 0, 131071, 1);
        for (int i = 0; i < 8; i++) drive(1, 0, 32767);
        idle(1);
        // Sat flag must not leak into the next vector
        push_exp(8, 0, 8, 0);
        for (int i = 0; i < 8; i++) drive(1, 0, 1);
        idle(1);

        // -32768 x8: -262144 fits 32 bits; clamps to -2^17 at 18 bits
        push_exp(relu(-262144), 0, relu(-131072), 1);
        for (int i = 0; i < 8; i++) drive(1, 0, -32768);
        idle(2);

        // Three terms, then restart with a new first term 2, then seven ones: 9
        d0 = drops_a;
        push_exp(9, 0, 9, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 1);
        drive(1, 1, 2);
        for (int i = 0; i < 7; i++) drive(1, 0, 1);
        idle(2);
        check("drop_restart_en_a", longint'(drops_a), longint'(d0 + 1));
        check("drop_restart_en_b", longint'(drops_b), longint'(d0 + 1));

        // restart alone in IDLE: nothing happens
        d0 = drops_a;
        drive(0, 1, 0);
        idle(2);
        check("no_drop_idle", longint'(drops_a), longint'(d0));
        check("busy_idle_restart", longint'(if_a.busy), 0);

        // restart alone in ACCUM: drop and back to IDLE, no result
        drive(1, 0, 7);
        drive(1, 0, 7);
        drive(0, 1, 0);
        check("busy_after_drop", longint'(if_a.busy), 0);
        idle(2);
        check("drop_restart_only", longint'(drops_a), longint'(d0 + 1));

        // Reset after four terms: outputs cleared, no pulses
        d0 = drops_a;
        for (int i = 0; i < 4; i++) drive(1, 0, 3);
        en  = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_result_a", longint'(if_a.result_out), 0);
        check("midrst_busy_a", longint'(if_a.busy), 0);
        check("midrst_result_b", longint'(if_b.result_out), 0);
        check("midrst_ovf_b", longint'(if_b.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        check("midrst_no_drop", longint'(drops_a), longint'(d0));
        check("midrst_valid", longint'(if_a.result_valid), 0);

        // Sixteen contiguous ones: two vectors of 8, pulses 8 cycles apart
        n0 = pulses_a.size();
        push_exp(8, 0, 8, 0);
        push_exp(8, 0, 8, 0);
        for (int i = 0; i < 16; i++) drive(1, 0, 1);
        idle(3);
        check("b2b_pulse_count", longint'(pulses_a.size()), longint'(n0 + 2));
        if (pulses_a.size() >= n0 + 2)
            check("b2b_spacing", longint'(pulses_a[n0 + 1] - pulses_a[n0]), 8);

        // Every expected result must have been observed
        check("a_pending", longint'(exp_a.size()), 0);
        check("b_pending", longint'(exp_b.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
